// File: rtl/traffic_pkg.sv
// traffic_pkg: lamp codes, controller phase encoding and lamp decode helpers
// shared by the intersection controller and the existing light block.
package traffic_pkg;

   localparam logic [2:0] LAMP_RED    = 3'b000;
   localparam logic [2:0] LAMP_GREEN  = 3'b001;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;

   // Phase encoding is also driven on the debug phase port.
   typedef enum logic [2:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      ALLRED_A  = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      ALLRED_B  = 3'd5,
      WALK      = 3'd6
   } phase_e;

   // North-south lamp for a given phase; red everywhere not listed.
   function automatic logic [2:0] ns_lamp(input phase_e st);
      case (st)
         NS_GREEN:  return LAMP_GREEN;
         NS_YELLOW: return LAMP_YELLOW;
         default:   return LAMP_RED;
      endcase
   endfunction

   // East-west lamp for a given phase; red everywhere not listed.
   function automatic logic [2:0] ew_lamp(input phase_e st);
      case (st)
         EW_GREEN:  return LAMP_GREEN;
         EW_YELLOW: return LAMP_YELLOW;
         default:   return LAMP_RED;
      endcase
   endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer: per-phase cycle counter. Cleared on reset or on a phase change,
// otherwise counts up and saturates so it can never wrap. o_done flags the
// last cycle of the current phase (count equals the supplied limit).
module phase_timer #(
   parameter int TW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_clr,
   input  logic [TW-1:0] i_limit,
   output logic [TW-1:0] o_count,
   output logic          o_done
);

   logic [TW-1:0] r_count;

   // Count cycles spent in the current phase, restarting at 0 on every entry.
   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_count <= '0;
      end else if (r_count != {TW{1'b1}}) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;
   assign o_done  = (r_count == i_limit);

endmodule

// File: rtl/intersection_ctrl.sv
// intersection_ctrl: two-way traffic light controller with demand-shortened
// north-south green. Optional pedestrian walk phase is built in when the
// macro INTERSECTION_PED_WALK_EN is defined; otherwise ped_req is ignored
// and walk is tied low.
module intersection_ctrl
   import traffic_pkg::*;
#(
   parameter int GREEN_MIN = 4,
   parameter int GREEN_MAX = 8,
   parameter int YELLOW_T  = 2,
   parameter int ALLRED_T  = 1,
   parameter int WALK_T    = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       car_ew,
   input  logic       ped_req,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic       walk,
   output logic [2:0] phase
);

   localparam int MAX_1 = (GREEN_MAX > GREEN_MIN) ? GREEN_MAX : GREEN_MIN;
   localparam int MAX_2 = (YELLOW_T > ALLRED_T) ? YELLOW_T : ALLRED_T;
   localparam int MAX_3 = (MAX_1 > MAX_2) ? MAX_1 : MAX_2;
   localparam int MAX_P = (MAX_3 > WALK_T) ? MAX_3 : WALK_T;
   localparam int TW    = $clog2(MAX_P + 1);

   // Last-cycle timer values for each phase length.
   localparam logic [TW-1:0] GMIN_L = TW'(GREEN_MIN - 1);
   localparam logic [TW-1:0] GMAX_L = TW'(GREEN_MAX - 1);
   localparam logic [TW-1:0] YEL_L  = TW'(YELLOW_T - 1);
   localparam logic [TW-1:0] ARED_L = TW'(ALLRED_T - 1);
`ifdef INTERSECTION_PED_WALK_EN
   localparam logic [TW-1:0] WALK_L = TW'(WALK_T - 1);
`endif

   phase_e        r_state;
   phase_e        w_next_state;
   logic [2:0]    r_ns_light;
   logic [2:0]    r_ew_light;
   logic [TW-1:0] w_count;
   logic [TW-1:0] w_limit;
   logic          w_done;
   logic          w_ped_pending;

   phase_timer #(.TW(TW)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_next_state != r_state),
      .i_limit (w_limit),
      .o_count (w_count),
      .o_done  (w_done)
   );

`ifdef INTERSECTION_PED_WALK_EN
   logic r_ped_pending;
   logic r_walk;

   // Latch a pedestrian press until the walk phase is actually entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ped_pending <= 1'b0;
      end else if (r_state == ALLRED_B && w_next_state == WALK) begin
         r_ped_pending <= 1'b0;
      end else if (ped_req) begin
         r_ped_pending <= 1'b1;
      end
   end

   assign w_ped_pending = r_ped_pending;
   assign walk          = r_walk;
`else
   logic w_unused_ped;
   assign w_unused_ped  = ped_req;
   assign w_ped_pending = 1'b0;
   assign walk          = 1'b0;
`endif

   // Select the final timer value of the current phase.
   always_comb begin
      w_limit = '0;
      case (r_state)
         NS_GREEN:  w_limit = GMAX_L;
         NS_YELLOW: w_limit = YEL_L;
         ALLRED_A:  w_limit = ARED_L;
         EW_GREEN:  w_limit = GMIN_L;
         EW_YELLOW: w_limit = YEL_L;
         ALLRED_B:  w_limit = ARED_L;
`ifdef INTERSECTION_PED_WALK_EN
         WALK:      w_limit = WALK_L;
`endif
         default:   w_limit = '0;
      endcase
   end

   // Next-phase selection; unknown encodings fall back to all-red.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         NS_GREEN:
            if (w_done || (w_count >= GMIN_L && (car_ew || w_ped_pending)))
               w_next_state = NS_YELLOW;
         NS_YELLOW: if (w_done) w_next_state = ALLRED_A;
         ALLRED_A:  if (w_done) w_next_state = EW_GREEN;
         EW_GREEN:  if (w_done) w_next_state = EW_YELLOW;
         EW_YELLOW: if (w_done) w_next_state = ALLRED_B;
`ifdef INTERSECTION_PED_WALK_EN
         ALLRED_B:  if (w_done) w_next_state = w_ped_pending ? WALK : NS_GREEN;
         WALK:      if (w_done) w_next_state = NS_GREEN;
`else
         ALLRED_B:  if (w_done) w_next_state = NS_GREEN;
`endif
         default:   w_next_state = ALLRED_B;
      endcase
   end

   // Phase register with lamp outputs registered alongside it, so lamps
   // always reflect the phase register exactly.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ALLRED_B;
         r_ns_light <= LAMP_RED;
         r_ew_light <= LAMP_RED;
`ifdef INTERSECTION_PED_WALK_EN
         r_walk     <= 1'b0;
`endif
      end else begin
         r_state    <= w_next_state;
         r_ns_light <= ns_lamp(w_next_state);
         r_ew_light <= ew_lamp(w_next_state);
`ifdef INTERSECTION_PED_WALK_EN
         r_walk     <= (w_next_state == WALK);
`endif
      end
   end

   assign ns_light = r_ns_light;
   assign ew_light = r_ew_light;
   assign phase    = r_state;

endmodule

// File: doc/intersection_ctrl.md
INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

Interface
REQ-001 SHALL have parameter GREEN_MIN, default 4: minimum NS green cycles; EW green length.
REQ-002 SHALL have parameter GREEN_MAX, default 8: maximum NS green cycles; GREEN_MAX >= GREEN_MIN.
REQ-003 SHALL have parameter YELLOW_T, default 2: yellow cycles per direction.
REQ-004 SHALL have parameter ALLRED_T, default 1: all-red clearance cycles.
REQ-005 SHALL have parameter WALK_T, default 3: pedestrian walk cycles; every parameter >= 1.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port car_ew, input, 1: EW vehicle waiting, level-sensitive.
REQ-009 SHALL have port ped_req, input, 1: pedestrian button, any-width pulse.
REQ-010 SHALL have port ns_light, output, 3: NS lamp code.
REQ-011 SHALL have port ew_light, output, 3: EW lamp code.
REQ-012 SHALL have port walk, output, 1: pedestrian walk lamp.
REQ-013 SHALL have port phase, output, 3: current state encoding, for debug.

Function
REQ-014 SHALL encode lamps as red=3'b000, green=3'b001, yellow=3'b010; no other codes driven.
REQ-015 SHALL implement states NS_GREEN, NS_YELLOW, ALLRED_A, EW_GREEN, EW_YELLOW, ALLRED_B, WALK.
REQ-016 SHALL decode outputs from the state register only: NS_GREEN ns=green; NS_YELLOW ns=yellow; EW_GREEN ew=green; EW_YELLOW ew=yellow; unlisted direction red in every state; walk=1 only in WALK.
REQ-017 SHALL clear the phase timer on every state entry; a state lasting N cycles drives its outputs for exactly N clocks.
REQ-018 SHALL leave NS_GREEN when timer >= GREEN_MIN-1 and (car_ew or ped_pending), or when timer == GREEN_MAX-1 regardless.
REQ-019 SHALL hold EW_GREEN exactly GREEN_MIN cycles, ignoring car_ew.
REQ-020 SHALL sequence NS_GREEN->NS_YELLOW->ALLRED_A->EW_GREEN->EW_YELLOW->ALLRED_B, with YELLOW_T and ALLRED_T durations.
REQ-021 SHALL exit ALLRED_B to WALK if ped_pending, else to NS_GREEN; WALK lasts WALK_T cycles, then goes to NS_GREEN.
REQ-022 SHALL set the ped_pending register on any cycle with ped_req=1 and clear it on the cycle entering WALK; clear wins on a simultaneous set and clear.
REQ-023 SHALL never drive green or yellow on both directions in the same cycle; illegal state encodings SHALL go to ALLRED_B.
REQ-024 SHALL size the timer as $clog2 of the largest parameter + 1; the timer SHALL not wrap within any state.

Reset
REQ-025 SHALL, while rst=1, force state ALLRED_B, timer 0, and ped_pending 0; outputs are then ns=red, ew=red, walk=0.
REQ-026 SHALL abort any state on reset mid-phase; the first cycle after rst deasserts is ALLRED_B timer 0.

Configuration
REQ-027 SHALL, with macro INTERSECTION_PED_WALK_EN defined, implement WALK and ped_pending per REQ-021/022.
REQ-028 SHALL, without INTERSECTION_PED_WALK_EN, omit WALK and ped_pending, ignore ped_req, tie walk to 0, and go from ALLRED_B to NS_GREEN always; ports are unchanged.

Structure
REQ-029 SHALL place the lamp codes, the state enum and the phase encoding in shared package traffic_pkg, reused by the existing light block.
REQ-030 SHALL use one sub-module phase_timer (load/clear, count, done compare); the FSM stays in intersection_ctrl.

Verification (defaults unless stated, macro on)
REQ-031 SHALL cover reset: rst=1 for 2 cycles, then release -> ns=ew=red, walk=0 for 1 cycle, then ns=green.
REQ-032 SHALL cover max green: car_ew=0, ped_req=0 -> ns green 8, yellow 2, all-red 1, ew green 4, yellow 2, all-red 1, ns green; repeating.
REQ-033 SHALL cover min green: car_ew=1 held -> ns green exactly 4 cycles before ns yellow.
REQ-034 SHALL cover a walk request: ped_req 1-cycle pulse during EW_GREEN -> after ALLRED_B, walk=1 for 3 cycles with both red, then ns green; ped_pending=0 afterward.
REQ-035 SHALL cover reset mid-phase: rst pulse during EW_GREEN with ped_pending=1 -> next cycle both red, no WALK follows unless ped_req is pressed again.
REQ-036 SHALL cover the macro-off build: ped_req pulses every 5 cycles -> walk stays 0 and the sequence matches REQ-032 exactly.
